// File: rtl/pq_alu_pkg.sv
// Shared definitions for the PQ ALU modular-multiply path: default widths,
// requester tag type and the Montgomery modulus configuration record.
package pq_alu_pkg;
  localparam int MM_LATENCY    = 2;
  localparam int PQ_NUM_REQ    = 4;
  localparam int PQ_DATA_WIDTH = 32;
  localparam int PQ_LOG_R      = 32;
  localparam int TAG_W         = $clog2(PQ_NUM_REQ);

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic [PQ_DATA_WIDTH-1:0] q;
    logic [PQ_LOG_R-1:0]      qdash;
  } mm_cfg_t;
endpackage

// File: rtl/multiplier.sv
// Combinational Montgomery multiplier: res = a*b*R^-1 mod q with R = 2^LOG_R.
// Fully reduced when a*b < q*R.
module multiplier #(
  parameter int DATA_WIDTH = 32,
  parameter int LOG_R      = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] q,
  input  logic [LOG_R-1:0]      qdash,
  output logic [DATA_WIDTH-1:0] res
);
  localparam int SW = DATA_WIDTH + LOG_R + 1;

  function automatic logic [DATA_WIDTH-1:0] cond_sub(input logic [DATA_WIDTH:0] x,
                                                     input logic [DATA_WIDTH-1:0] m);
    logic [DATA_WIDTH:0] mx;
    mx = {1'b0, m};
    return (x >= mx) ? DATA_WIDTH'(x - mx) : DATA_WIDTH'(x);
  endfunction

  logic [2*DATA_WIDTH-1:0] t;
  logic [LOG_R-1:0]        m;
  logic [SW-1:0]           sum;
  logic [DATA_WIDTH:0]     u;

  // REDC: t + m*q is divisible by R, and the quotient is below 2q
  always_comb begin
    t   = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
    m   = t[LOG_R-1:0] * qdash;
    sum = SW'(t) + SW'(m) * SW'(q);
    u   = (DATA_WIDTH+1)'(sum >> LOG_R);
    res = cond_sub(u, q);
  end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: first eligible requester at or after rr_ptr.
module rr_arbiter
  import pq_alu_pkg::*;
#(
  parameter int NUM_REQ = PQ_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  tag_t               rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output tag_t               grant_idx,
  output logic               grant_any
);
  always_comb begin
    int   idx;
    tag_t sel;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      sel = tag_t'(idx);
      if (!grant_any && eligible[sel]) begin
        grant[sel] = 1'b1;
        grant_idx  = sel;
        grant_any  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mont_mul_arbiter.sv
// Shares one Montgomery multiplier between NUM_REQ requesters: round-robin issue
// stage, registered result stage, and one held response slot per requester.
module mont_mul_arbiter
  import pq_alu_pkg::*;
#(
  parameter int NUM_REQ    = PQ_NUM_REQ,
  parameter int DATA_WIDTH = PQ_DATA_WIDTH,
  parameter int LOG_R      = PQ_LOG_R
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                cfg_we_i,
  input  logic [DATA_WIDTH-1:0]               cfg_q_i,
  input  logic [LOG_R-1:0]                    cfg_qdash_i,
  output logic                                cfg_busy_o,
  output logic                                cfg_err_o,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_op0_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_op1_i,
  output logic [NUM_REQ-1:0]                  rsp_valid_o,
  input  logic [NUM_REQ-1:0]                  rsp_ready_i,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  rsp_data_o
);
  mm_cfg_t                            cfg_reg;
  logic                               cfg_ok;
  logic                               cfg_err;
  tag_t                               rr_ptr;
  logic                               vld_p1;
  tag_t                               tag_p1;
  logic [DATA_WIDTH-1:0]              op0_p1;
  logic [DATA_WIDTH-1:0]              op1_p1;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rsp_data;
  logic [NUM_REQ-1:0]                 pending;
  logic [NUM_REQ-1:0]                 eligible;
  logic [NUM_REQ-1:0]                 grant;
  tag_t                               grant_idx;
  logic                               grant_any;
  logic                               busy;
  logic                               cfg_load;
  logic [DATA_WIDTH-1:0]              mm_res;

  // A config load steals its cycle from the arbiter so no op sees a half-updated modulus
  always_comb begin
    busy     = vld_p1 | (|rsp_valid);
    cfg_load = cfg_we_i & ~busy;
    for (int i = 0; i < NUM_REQ; i++) begin
      pending[i] = (vld_p1 && (tag_p1 == tag_t'(i))) | rsp_valid[i];
    end
    eligible = req_valid_i & ~pending & {NUM_REQ{cfg_ok & ~cfg_load}};
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_reg <= '0;
      cfg_ok  <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we_i & busy;
      if (cfg_load) begin
        cfg_reg.q     <= cfg_q_i;
        cfg_reg.qdash <= cfg_qdash_i;
        cfg_ok        <= 1'b1;
      end
    end
  end

  // S1: issue
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= grant_any;
      if (grant_any) begin
        rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant_any) begin
      op0_p1 <= req_op0_i[grant_idx];
      op1_p1 <= req_op1_i[grant_idx];
      tag_p1 <= grant_idx;
    end
  end

  multiplier #(.DATA_WIDTH(DATA_WIDTH), .LOG_R(LOG_R)) u_mm (
    .a     (op0_p1),
    .b     (op1_p1),
    .q     (cfg_reg.q),
    .qdash (cfg_reg.qdash),
    .res   (mm_res)
  );

  // S2: result slots; a slot is never written while it still holds a result
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (vld_p1 && (tag_p1 == tag_t'(i))) begin
          rsp_valid[i] <= 1'b1;
          rsp_data[i]  <= mm_res;
        end else if (rsp_ready_i[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign req_ready_o = grant;
  assign rsp_valid_o = rsp_valid;
  assign rsp_data_o  = rsp_data;
  assign cfg_busy_o  = busy;
  assign cfg_err_o   = cfg_err;
endmodule

// File: tb/tb_mont_mul_arbiter.sv
// Directed bench for mont_mul_arbiter with Dilithium parameters; expected results
// come from a halving-based modular model and are matched through per-slot queues.
module tb_mont_mul_arbiter;
  import pq_alu_pkg::*;

  localparam int N = 4;
  localparam longint unsigned Q     = 64'd8380417;
  localparam longint unsigned QD    = 64'd4236238847;
  localparam longint unsigned RMODQ = 64'd4193792;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [31:0]      cfg_q;
  logic [31:0]      cfg_qdash;
  logic             cfg_busy;
  logic             cfg_err;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N-1:0][31:0] op0;
  logic [N-1:0][31:0] op1;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ready;
  logic [N-1:0][31:0] rsp_data;

  always #5 clk = ~clk;

  mont_mul_arbiter #(.NUM_REQ(N), .DATA_WIDTH(32), .LOG_R(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_we_i    (cfg_we),
    .cfg_q_i     (cfg_q),
    .cfg_qdash_i (cfg_qdash),
    .cfg_busy_o  (cfg_busy),
    .cfg_err_o   (cfg_err),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op0_i   (op0),
    .req_op1_i   (op1),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t            exp_q[N][$];
  bit              seen[N];
  int              grant_log[$];
  int              gcount[N];
  int              compared   = 0;
  int              mismatched = 0;
  int              cyc        = 0;
  longint unsigned model_q;
  logic [31:0]     held1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // x with x*2^32 == a*b (mod q): divide by two 32 times using (q+1)/2 as 1/2
  function automatic logic [31:0] mont_model(input longint unsigned a, input longint unsigned b,
                                             input longint unsigned q);
    longint unsigned p;
    p = (a * b) % q;
    for (int k = 0; k < 32; k++) p = p[0] ? (p + q) >> 1 : p >> 1;
    return p[31:0];
  endfunction

  task automatic set_rand_ops();
    for (int i = 0; i < N; i++) begin
      op0[i] = $urandom_range(0, 32'(Q - 1));
      op1[i] = $urandom_range(0, 32'(Q - 1));
    end
  endtask

  task automatic clear_sb();
    for (int i = 0; i < N; i++) begin
      exp_q[i].delete();
      seen[i] = 1'b0;
    end
  endtask

  // One cycle: sample away from the edge, score responses, log accepts, advance.
  task automatic tick();
    exp_t e;
    #1;
    for (int i = 0; i < N; i++) begin
      if (rsp_valid[i]) begin
        if (exp_q[i].size() == 0) begin
          check($sformatf("spurious_rsp%0d", i), rsp_valid[i], 1'b0);
        end else begin
          check($sformatf("rsp_data%0d", i), rsp_data[i], exp_q[i][0].data);
          if (!seen[i]) check($sformatf("rsp_latency%0d", i), cyc, exp_q[i][0].due);
          seen[i] = 1'b1;
          if (rsp_ready[i]) begin
            void'(exp_q[i].pop_front());
            seen[i] = 1'b0;
          end
        end
      end else if (exp_q[i].size() != 0 && cyc > exp_q[i][0].due) begin
        check($sformatf("rsp_late%0d", i), cyc, exp_q[i][0].due);
      end
    end
    check("ready_onehot", $onehot0(req_ready), 1'b1);
    check("ready_subset", req_ready & ~req_valid, '0);
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.data = mont_model(op0[i], op1[i], model_q);
        e.due  = cyc + MM_LATENCY;
        exp_q[i].push_back(e);
        grant_log.push_back(i);
        gcount[i]++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_q = '0; cfg_qdash = '0;
    req_valid = '0; op0 = '0; op1 = '0; rsp_ready = '1;
    model_q = Q;
    clear_sb();
    for (int i = 0; i < N; i++) gcount[i] = 0;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_req_ready", req_ready, '0);
    check("rst_busy", cfg_busy, 1'b0);
    check("rst_err", cfg_err, 1'b0);
    check("rst_rsp_data", rsp_data, '0);
    rst = 1'b0;

    // Unconfigured: nobody is ever granted
    req_valid = 4'b1111;
    set_rand_ops();
    for (int k = 0; k < 10; k++) begin
      tick();
      check("nocfg_ready", req_ready, '0);
    end

    // Config write; its own cycle issues no grant
    cfg_we = 1'b1; cfg_q = 32'(Q); cfg_qdash = 32'(QD);
    #1 check("cfg_cycle_ready", req_ready, '0);
    tick();
    cfg_we = 1'b0; req_valid = '0;
    check("cfg_err_idle", cfg_err, 1'b0);
    check("cfg_busy_idle", cfg_busy, 1'b0);

    // R mod q times 1234 comes back as 1234
    req_valid = 4'b0001; op0[0] = 32'(RMODQ); op1[0] = 32'd1234;
    #1 check("single_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    check("single_busy", cfg_busy, 1'b1);
    tick();
    check("single_rsp_valid", rsp_valid, 4'b0001);
    check("single_rsp_data", rsp_data[0], 32'd1234);
    repeat (2) tick();

    // Everyone asking every cycle: rotation starts after the last grantee (req0)
    grant_log.delete();
    req_valid = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      set_rand_ops();
      tick();
    end
    req_valid = '0;
    repeat (3) tick();
    check("rr_grant_count", grant_log.size(), 16);
    for (int k = 0; k < 16 && k < grant_log.size(); k++) begin
      check($sformatf("rr_order%0d", k), grant_log[k], (1 + k) % N);
    end

    // Requester 1 stops consuming: it is never re-granted, the rest keep going
    rsp_ready = 4'b1101; req_valid = 4'b1111;
    repeat (3) begin set_rand_ops(); tick(); end
    held1 = rsp_data[1];
    for (int i = 0; i < N; i++) gcount[i] = 0;
    repeat (12) begin set_rand_ops(); tick(); end
    check("held_no_regrant", gcount[1], 0);
    check("held_others_rate", gcount[0] + gcount[2] + gcount[3], 12);
    check("held_valid", rsp_valid[1], 1'b1);
    check("held_data_stable", rsp_data[1], held1);
    rsp_ready = 4'b1111; req_valid = 4'b0010;
    for (int i = 0; i < N; i++) gcount[i] = 0;
    repeat (3) tick();
    check("release_regrant", gcount[1], 1);
    req_valid = '0;
    repeat (3) tick();

    // Config write while an op is in flight is dropped and flagged
    req_valid = 4'b0001; set_rand_ops();
    tick();
    req_valid = '0;
    cfg_we = 1'b1; cfg_q = 32'd12289; cfg_qdash = 32'd12287;
    check("inflight_busy", cfg_busy, 1'b1);
    tick();
    cfg_we = 1'b0;
    check("cfg_err_pulse", cfg_err, 1'b1);
    tick();
    check("cfg_err_clear", cfg_err, 1'b0);
    repeat (2) tick();
    req_valid = 4'b0010;
    op0[1] = 32'(Q - 1); op1[1] = 32'(Q - 2);
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Idle config rewrite with requesters waiting: no grant in that cycle
    req_valid = 4'b1111; cfg_we = 1'b1; cfg_q = 32'(Q); cfg_qdash = 32'(QD);
    #1 check("cfg_idle_nogrant", req_ready, '0);
    tick();
    cfg_we = 1'b0;
    check("cfg_idle_err", cfg_err, 1'b0);
    set_rand_ops();
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Async reset with S1 occupied and slots 0 and 2 held
    rsp_ready = '0; set_rand_ops();
    req_valid = 4'b0001; tick();
    req_valid = 4'b0100; tick();
    req_valid = 4'b0010; tick();
    req_valid = '0;
    check("pre_rst_rsp_valid", rsp_valid, 4'b0101);
    check("pre_rst_busy", cfg_busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, '0);
    check("mid_rst_rsp_data", rsp_data, '0);
    check("mid_rst_busy", cfg_busy, 1'b0);
    check("mid_rst_err", cfg_err, 1'b0);
    clear_sb();
    #1 rst = 1'b0;
    @(negedge clk);
    rsp_ready = '1; req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("post_rst_ready", req_ready, '0);
      check("post_rst_rsp_valid", rsp_valid, '0);
    end
    req_valid = '0;

    for (int i = 0; i < N; i++) check($sformatf("sb_empty%0d", i), exp_q[i].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
